// File: rtl/bus_mux_pkg.sv
// Shared types and helpers for the round-robin bus multiplexer.
package bus_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Wide enough for the largest hold limit (15).
  localparam int HOLD_W = 4;

  // Increment an index modulo n; anything at or past n-1 wraps to 0.
  function automatic logic [31:0] inc_mod(input logic [31:0] v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_mux_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr,
// wrapping modulo NUM_SRC. Produces one-hot grant, its index and any-request.
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  logic [31:0] cand;

  // Walk NUM_SRC candidates from ptr; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 32'(ptr_i);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any_o && req_i[cand[SEL_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[SEL_W-1:0];
      end
      cand = inc_mod(cand, NUM_SRC);
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with round-robin arbitration, a hold limit per
// grant, and a forced-select override that freezes the arbitration state.
module bus_arbiter_mux
  import bus_mux_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 32,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int MAX_HOLD = 4
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic [SEL_W-1:0]          grant_sel,
  output logic                      sel_err
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SEL_W-1:0]     g_q, g_d;        // arbitrated owner, kept across forced mode
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]    bus_q, bus_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [SEL_W-1:0]     g_next;
  logic [SEL_W-1:0]     arb_ptr;
  logic [NUM_SRC-1:0]   arb_gnt;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [DATA_W-1:0]    arb_word, g_word, frc_word;
  logic                 frc_bad;

  // In GRANT a rearbitration always starts just past the current owner.
  assign g_next  = SEL_W'(inc_mod(32'(g_q), NUM_SRC));
  assign arb_ptr = (state_q == GRANT) ? g_next : ptr_q;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr (
    .req_i (src_req),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign arb_word = src_data[arb_idx*DATA_W +: DATA_W];
  assign g_word   = src_data[g_q*DATA_W +: DATA_W];
  assign frc_word = src_data[force_sel*DATA_W +: DATA_W];
  assign frc_bad  = 32'(force_sel) >= NUM_SRC;

  // Next-state and next-output selection: forced mode, then FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    g_d     = g_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    bus_d   = bus_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (force_en) begin
      // Arbitration state is frozen; only the output registers move.
      if (frc_bad) begin
        grant_d = '0;
        bus_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end else begin
        grant_d = NUM_SRC'(1) << force_sel;
        sel_d   = force_sel;
        bus_d   = frc_word;
        valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_d = GRANT;
            g_d     = arb_idx;
            hold_d  = HOLD_W'(1);
            grant_d = arb_gnt;
            sel_d   = arb_idx;
            bus_d   = arb_word;
            valid_d = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
        GRANT: begin
          if (!src_req[g_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
            // Grant ends by release or expiry; ptr moves past the owner.
            ptr_d = g_next;
            if (arb_any) begin
              g_d     = arb_idx;
              hold_d  = HOLD_W'(1);
              grant_d = arb_gnt;
              sel_d   = arb_idx;
              bus_d   = arb_word;
              valid_d = 1'b1;
            end else begin
              state_d = IDLE;
              hold_d  = '0;
              grant_d = '0;
              valid_d = 1'b0;
            end
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
            grant_d = NUM_SRC'(1) << g_q;
            sel_d   = g_q;
            bus_d   = g_word;
            valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      g_q     <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign grant     = grant_q;
  assign grant_sel = sel_q;
  assign sel_err   = err_q;

endmodule
